// File: rtl/sparse_mult_pkg.sv
// Shared types and default sizing for the sparse polynomial multiply datapath.
package sparse_mult_pkg;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned MEM_SIZE        = 553;
  localparam int unsigned MEM_SPARSE_SIZE = 50;
  localparam int unsigned ADDR_WIDTH      = 10;
  localparam int unsigned CNT_WIDTH       = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT_DONE,
    RESTART,
    FINISH
  } state_e;

endpackage

// File: rtl/acc_port_mux.sv
// Accumulator memory port selection: scheduler clear writes or controller
// pass-through, with controller writes gated outside jobs and on dummy terms.
module acc_port_mux #(
  parameter int unsigned ADDR_WIDTH = sparse_mult_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = sparse_mult_pkg::WORD_WIDTH
) (
  input  logic                  clear_sel_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic                  pass_we_en_i,
  input  logic                  dummy_i,
  input  logic [ADDR_WIDTH-1:0] ctrl_acc_addr_i,
  input  logic                  ctrl_acc_we_i,
  input  logic [WORD_WIDTH-1:0] ctrl_acc_wdata_i,
  output logic [ADDR_WIDTH-1:0] acc_mem_addr_o,
  output logic                  acc_mem_we_o,
  output logic [WORD_WIDTH-1:0] acc_mem_wdata_o
);

  // Controller path by default so its reads work in any state; clear overrides.
  always_comb begin
    acc_mem_addr_o  = ctrl_acc_addr_i;
    acc_mem_we_o    = ctrl_acc_we_i & pass_we_en_i & ~dummy_i;
    acc_mem_wdata_o = ctrl_acc_wdata_i;
    if (clear_sel_i) begin
      acc_mem_addr_o  = clr_addr_i;
      acc_mem_we_o    = 1'b1;
      acc_mem_wdata_o = '0;
    end
  end

endmodule

// File: rtl/sparse_term_scheduler.sv
// Top-level sequencer: clears the accumulator, then runs one controller job
// per sparse term. Optional macro SPARSE_DUMMY_INSERT_EN pads every run to
// MEM_SPARSE_SIZE jobs, masking writes of the padding (dummy) terms.
module sparse_term_scheduler
  import sparse_mult_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = sparse_mult_pkg::WORD_WIDTH,
  parameter int unsigned MEM_SIZE        = sparse_mult_pkg::MEM_SIZE,
  parameter int unsigned MEM_SPARSE_SIZE = sparse_mult_pkg::MEM_SPARSE_SIZE,
  parameter int unsigned ADDR_WIDTH      = sparse_mult_pkg::ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH       = sparse_mult_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  term_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  ctrl_start_o,
  output logic [ADDR_WIDTH-1:0] ctrl_sparse_addr_o,
  output logic                  ctrl_restart_o,
  input  logic                  ctrl_done_i,
  input  logic [ADDR_WIDTH-1:0] ctrl_acc_addr_i,
  input  logic                  ctrl_acc_we_i,
  input  logic [WORD_WIDTH-1:0] ctrl_acc_wdata_i,
  output logic [ADDR_WIDTH-1:0] acc_mem_addr_o,
  output logic                  acc_mem_we_o,
  output logic [WORD_WIDTH-1:0] acc_mem_wdata_o
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST   = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  SPARSE_MAX = CNT_WIDTH'(MEM_SPARSE_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_WIDTH-1:0]  term_idx_q, term_idx_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic [ADDR_WIDTH-1:0] sparse_addr_q, sparse_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  ctrl_start_q, ctrl_start_d;
  logic                  ctrl_restart_q, ctrl_restart_d;
  logic                  done_prev_q;

  logic                  accept_c;
  logic                  done_rise_c;
  logic [CNT_WIDTH-1:0]  start_total_c;
  logic [CNT_WIDTH-1:0]  term_idx_inc_c;
  logic                  dummy_c;

  assign accept_c       = (state_q == IDLE) && start && (term_count <= SPARSE_MAX);
  assign done_rise_c    = ctrl_done_i & ~done_prev_q;
  assign term_idx_inc_c = term_idx_q + CNT_WIDTH'(1);

`ifdef SPARSE_DUMMY_INSERT_EN
  logic [CNT_WIDTH-1:0] real_cnt_q;

  // Remember how many terms are real; later terms are padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_cnt_q <= '0;
    end else if (accept_c) begin
      real_cnt_q <= term_count;
    end
  end

  assign start_total_c = SPARSE_MAX;
  assign dummy_c       = (term_idx_q >= real_cnt_q);
`else
  assign start_total_c = term_count;
  assign dummy_c       = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      clr_cnt_q      <= '0;
      term_idx_q     <= '0;
      total_q        <= '0;
      sparse_addr_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      ctrl_start_q   <= 1'b0;
      ctrl_restart_q <= 1'b0;
      done_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      term_idx_q     <= term_idx_d;
      total_q        <= total_d;
      sparse_addr_q  <= sparse_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      ctrl_start_q   <= ctrl_start_d;
      ctrl_restart_q <= ctrl_restart_d;
      done_prev_q    <= ctrl_done_i;
    end
  end

  // Next state; pulse outputs are raised on the transition into their state.
  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    term_idx_d     = term_idx_q;
    total_d        = total_q;
    sparse_addr_d  = sparse_addr_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    ctrl_start_d   = 1'b0;
    ctrl_restart_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          total_d   = start_total_c;
          busy_d    = 1'b1;
          clr_cnt_d = '0;
          state_d   = CLEAR;
        end else if (start) begin
          error_d = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          term_idx_d = '0;
          if (total_q == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d       = ISSUE;
            ctrl_start_d  = 1'b1;
            sparse_addr_d = '0;
          end
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise_c) begin
          state_d        = RESTART;
          ctrl_restart_d = 1'b1;
        end
      end
      RESTART: begin
        term_idx_d = term_idx_inc_c;
        if (term_idx_inc_c == total_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d       = ISSUE;
          ctrl_start_d  = 1'b1;
          sparse_addr_d = ADDR_WIDTH'(term_idx_inc_c);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign ctrl_start_o       = ctrl_start_q;
  assign ctrl_restart_o     = ctrl_restart_q;
  assign ctrl_sparse_addr_o = sparse_addr_q;

  acc_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_acc_port_mux (
    .clear_sel_i      (state_q == CLEAR),
    .clr_addr_i       (clr_cnt_q),
    .pass_we_en_i     (state_q == WAIT_DONE),
    .dummy_i          (dummy_c),
    .ctrl_acc_addr_i  (ctrl_acc_addr_i),
    .ctrl_acc_we_i    (ctrl_acc_we_i),
    .ctrl_acc_wdata_i (ctrl_acc_wdata_i),
    .acc_mem_addr_o   (acc_mem_addr_o),
    .acc_mem_we_o     (acc_mem_we_o),
    .acc_mem_wdata_o  (acc_mem_wdata_o)
  );

endmodule

// File: tb/tb_sparse_term_scheduler.sv
// Bench for sparse_term_scheduler: a randomised controller model plus a
// monitor that tallies observed events, compared against expectations derived
// from the term count, controller latency and clear length.
module tb_sparse_term_scheduler;

  localparam int MS   = sparse_mult_pkg::MEM_SIZE;
  localparam int MSS  = sparse_mult_pkg::MEM_SPARSE_SIZE;
  localparam int AW   = sparse_mult_pkg::ADDR_WIDTH;
  localparam int WW   = sparse_mult_pkg::WORD_WIDTH;
  localparam int CW   = sparse_mult_pkg::CNT_WIDTH;
`ifdef SPARSE_DUMMY_INSERT_EN
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam bit DUMMY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] term_count;
  logic          busy, done, error;
  logic          ctrl_start_o, ctrl_restart_o;
  logic [AW-1:0] ctrl_sparse_addr_o;
  logic          ctrl_done_i;
  logic [AW-1:0] ctrl_acc_addr_i;
  logic          ctrl_acc_we_i;
  logic [WW-1:0] ctrl_acc_wdata_i;
  logic [AW-1:0] acc_mem_addr_o;
  logic          acc_mem_we_o;
  logic [WW-1:0] acc_mem_wdata_o;

  sparse_term_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .term_count         (term_count),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .ctrl_start_o       (ctrl_start_o),
    .ctrl_sparse_addr_o (ctrl_sparse_addr_o),
    .ctrl_restart_o     (ctrl_restart_o),
    .ctrl_done_i        (ctrl_done_i),
    .ctrl_acc_addr_i    (ctrl_acc_addr_i),
    .ctrl_acc_we_i      (ctrl_acc_we_i),
    .ctrl_acc_wdata_i   (ctrl_acc_wdata_i),
    .acc_mem_addr_o     (acc_mem_addr_o),
    .acc_mem_we_o       (acc_mem_we_o),
    .acc_mem_wdata_o    (acc_mem_wdata_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation log
  int cyc = 0;
  int clr_wr_n, clr_bad, clr_next, ctrl_wr_seen, pass_bad, exp_pass;
  int restart_n, done_n, done_cyc, error_n, error_cyc, first_start_cyc;
  bit busy_seen, busy_prev, busy_at_done, busy_before_done;
  int start_addrs[$];

  // Controller model state
  bit job_active;
  int job_idx, started_n, timer, hold;
  int lat_cfg = 20;
  bit early = 1'b0;
  int early_hold = 6;
  int cur_tc = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_dummy(input int j);
    return DUMMY_EN && (j >= cur_tc);
  endfunction

  task automatic clear_log();
    clr_wr_n = 0; clr_bad = 0; clr_next = 0; ctrl_wr_seen = 0; pass_bad = 0;
    exp_pass = 0; restart_n = 0; done_n = 0; done_cyc = 0; error_n = 0;
    error_cyc = 0; first_start_cyc = 0; busy_seen = 0; busy_prev = 0;
    busy_at_done = 0; busy_before_done = 0; started_n = 0;
    start_addrs.delete();
  endtask

  // Monitor first, then advance the controller model, once per falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (acc_mem_we_o === 1'b1) begin
        if (!job_active) begin
          clr_wr_n++;
          if (acc_mem_addr_o !== AW'(clr_next) || acc_mem_wdata_o !== '0) clr_bad++;
          clr_next++;
        end else begin
          ctrl_wr_seen++;
          if (acc_mem_addr_o !== ctrl_acc_addr_i || acc_mem_wdata_o !== ctrl_acc_wdata_i)
            pass_bad++;
        end
      end
      if (busy === 1'b1) busy_seen = 1;
      if (done === 1'b1) begin
        done_n++; done_cyc = cyc; busy_at_done = busy; busy_before_done = busy_prev;
      end
      busy_prev = busy;
      if (error === 1'b1) begin error_n++; error_cyc = cyc; end
      if (ctrl_restart_o === 1'b1) restart_n++;
      if (ctrl_start_o === 1'b1) begin
        start_addrs.push_back(int'(ctrl_sparse_addr_o));
        if (first_start_cyc == 0) first_start_cyc = cyc;
      end

      if (rst_n) begin
        if (ctrl_restart_o === 1'b1) begin
          ctrl_done_i = 1'b0;
          job_active  = 1'b0;
        end
        if (ctrl_start_o === 1'b1) begin
          job_active = 1'b1;
          job_idx    = started_n;
          started_n++;
          timer      = lat_cfg;
          hold       = 0;
          if (early) begin
            ctrl_done_i = 1'b1;
            hold        = early_hold;
          end
        end else if (job_active) begin
          if (hold > 0) begin
            hold--;
            if (hold == 0) ctrl_done_i = 1'b0;
          end else if (!ctrl_done_i) begin
            timer--;
            if (timer == 0) ctrl_done_i = 1'b1;
          end
        end
        ctrl_acc_addr_i  = AW'($urandom);
        ctrl_acc_wdata_i = WW'($urandom);
        ctrl_acc_we_i    = 1'b0;
        if (job_active && !ctrl_done_i) begin
          ctrl_acc_we_i = 1'($urandom_range(0, 1));
          if (ctrl_acc_we_i && !is_dummy(job_idx)) exp_pass++;
        end
      end
    end
  end

  task automatic do_start(input int tc, output int c0);
    @(negedge clk); #1;
    term_count = CW'(tc);
    start      = 1'b1;
    c0         = cyc;
    @(negedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done_n == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, " done_within_budget"}, longint'(done_n > 0), 1);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (start_addrs.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, " starts_within_budget"}, longint'(start_addrs.size() >= n), 1);
  endtask

  // One full accepted run with checks derived from term count and latency.
  task automatic run_scenario(input string tag, input int tc, input int lat, output int dur);
    int c0, total, bad_addr;
    clear_log();
    lat_cfg = lat;
    cur_tc  = tc;
    total   = DUMMY_EN ? MSS : tc;
    do_start(tc, c0);
    wait_done(tag, 4000);
    repeat (3) @(negedge clk);
    #1;
    dur = done_cyc - c0;
    chk({tag, " clear_writes"}, clr_wr_n, MS);
    chk({tag, " clear_addr_data"}, clr_bad, 0);
    chk({tag, " jobs_issued"}, start_addrs.size(), total);
    bad_addr = 0;
    foreach (start_addrs[i]) if (start_addrs[i] != i) bad_addr++;
    chk({tag, " job_addrs"}, bad_addr, 0);
    chk({tag, " restarts"}, restart_n, total);
    chk({tag, " done_once"}, done_n, 1);
    chk({tag, " busy_low_at_done"}, busy_at_done, 0);
    chk({tag, " busy_high_before_done"}, busy_before_done, 1);
    chk({tag, " busy_idle_after"}, busy, 0);
    chk({tag, " run_cycles"}, dur, MS + 1 + total * (lat + 2));
    if (total > 0) chk({tag, " first_job_latency"}, first_start_cyc - c0, MS + 1);
    chk({tag, " passed_ctrl_writes"}, ctrl_wr_seen, exp_pass);
    chk({tag, " passthrough_addr_data"}, pass_bad, 0);
    chk({tag, " no_error"}, error_n, 0);
  endtask

  initial begin
    int c0, dur, d2, d50, tc, lat;
    rst_n = 1'b1; start = 1'b0; term_count = '0; ctrl_done_i = 1'b0;
    ctrl_acc_addr_i = '0; ctrl_acc_we_i = 1'b0; ctrl_acc_wdata_i = '0;
    job_active = 1'b0; clear_log();
    #1 rst_n = 1'b0;
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset ctrl_start", ctrl_start_o, 0);
    chk("reset ctrl_restart", ctrl_restart_o, 0);
    chk("reset sparse_addr", ctrl_sparse_addr_o, 0);
    chk("reset acc_we", acc_mem_we_o, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    run_scenario("tc3", 3, 20, dur);

    clear_log();
    do_start(MSS + 1, c0);
    repeat (6) @(negedge clk);
    #1;
    chk("over error_pulses", error_n, 1);
    chk("over error_next_cycle", error_cyc - c0, 1);
    chk("over no_acc_writes", clr_wr_n + ctrl_wr_seen, 0);
    chk("over busy_never", busy_seen, 0);
    chk("over no_done", done_n, 0);

    run_scenario("tc0", 0, 4, dur);

    for (int r = 0; r < 2; r++) begin
      tc  = $urandom_range(1, MSS);
      lat = $urandom_range(1, 12);
      run_scenario($sformatf("rand%0d_tc%0d_lat%0d", r, tc, lat), tc, lat, dur);
    end

    run_scenario("tc2", 2, 6, d2);
    run_scenario("tc50", MSS, 6, d50);
    chk("runtime_delta_tc50_vs_tc2", d50 - d2, DUMMY_EN ? 0 : (MSS - 2) * 8);

    // Controller done already high on entry to WAIT_DONE must not count.
    clear_log();
    early = 1'b1; early_hold = 6; lat_cfg = 5; cur_tc = 1;
    do_start(1, c0);
    wait_starts("sticky", 1, 1000);
    repeat (5) @(negedge clk);
    #1;
    chk("sticky no_restart_while_held", restart_n, 0);
    wait_done("sticky", 4000);
    repeat (2) @(negedge clk);
    #1;
    chk("sticky restarts", restart_n, DUMMY_EN ? MSS : 1);
    chk("sticky done_once", done_n, 1);
    early = 1'b0;

    // Asynchronous reset in the middle of job 1.
    clear_log();
    lat_cfg = 20; cur_tc = 3;
    do_start(3, c0);
    wait_starts("midrst", 2, 2000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst ctrl_start", ctrl_start_o, 0);
    chk("midrst ctrl_restart", ctrl_restart_o, 0);
    chk("midrst sparse_addr", ctrl_sparse_addr_o, 0);
    chk("midrst acc_we", acc_mem_we_o, 0);
    ctrl_done_i = 1'b0; ctrl_acc_we_i = 1'b0; job_active = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst only_job0_restarted", restart_n, 1);
    chk("midrst no_done", done_n, 0);
    rst_n = 1'b1;
    run_scenario("after_rst", 3, 20, dur);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a loop bound is ever bypassed.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
